sgmii_reg_responder: RTL and testbench

// - Responder end of the SGMII PCS management register bus (reg_addr/reg_wr/reg_rd/reg_busy).
// - Holds the PCS control, status, link_timer and if_mode registers and drives PCS-core config outputs.
// - Emulates the PCS handshake seen by the config master: busy high = ready/processing, busy low = done.
// - Used as the PCS-side register block and as a bench model for the config FSM.

---
 rtl/sgmii_reg_responder_pkg.sv | 40 ++++
 rtl/sgmii_reg_if.sv | 30 +++
 rtl/sgmii_reg_file.sv | 92 +++++++++
 rtl/sgmii_reg_responder.sv | 108 ++++++++++
 tb/tb_sgmii_reg_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgmii_reg_responder_pkg.sv
// Shared definitions for the SGMII PCS management register responder.
// Register map addresses, reset values, status layout and FSM states.
package sgmii_reg_responder_pkg;

   localparam logic [4:0] ADDR_CTRL    = 5'h00;
   localparam logic [4:0] ADDR_STAT    = 5'h01;
   localparam logic [4:0] ADDR_SCRATCH = 5'h10;
   localparam logic [4:0] ADDR_LT_LO   = 5'h12;
   localparam logic [4:0] ADDR_LT_HI   = 5'h13;
   localparam logic [4:0] ADDR_IF_MODE = 5'h14;

   localparam logic [15:0] CTRL_RST = 16'h1140;

   localparam int CTRL_SW_RESET   = 15;
   localparam int CTRL_AN_EN      = 12;
   localparam int CTRL_AN_RESTART = 9;

   localparam int STAT_AN_DONE = 5;
   localparam int STAT_ONE     = 3;
   localparam int STAT_LINK    = 2;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   // Status word assembled from live PCS inputs.
   function automatic logic [15:0] status_word(input logic link,
                                               input logic an);
      logic [15:0] s;
      s = '0;
      s[STAT_AN_DONE] = an;
      s[STAT_ONE]     = 1'b1;
      s[STAT_LINK]    = link;
      return s;
   endfunction

endpackage

// File: rtl/sgmii_reg_if.sv
// Management register bus between config master and PCS responder.
// Requests are levels held by the master; busy is driven by the responder.
interface sgmii_reg_if;

   logic [4:0]  reg_addr;
   logic        reg_wr;
   logic        reg_rd;
   logic [15:0] reg_data_in;
   logic [15:0] reg_data_out;
   logic        reg_busy;

   modport master (
      output reg_addr,
      output reg_wr,
      output reg_rd,
      output reg_data_in,
      input  reg_data_out,
      input  reg_busy
   );

   modport slave (
      input  reg_addr,
      input  reg_wr,
      input  reg_rd,
      input  reg_data_in,
      output reg_data_out,
      output reg_busy
   );

endinterface

// File: rtl/sgmii_reg_file.sv
// PCS register map: storage, read mux, soft-reset timer, AN restart pulse.
// Writes and read captures happen only on the commit strobe from the FSM.
module sgmii_reg_file
   import sgmii_reg_responder_pkg::*;
#(
   parameter int RESET_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit,
   input  logic        op_wr,
   input  logic [4:0]  addr,
   input  logic [15:0] wdata,
   input  logic        link_up,
   input  logic        an_done,
   output logic [15:0] rdata,
   output logic [20:0] link_timer,
   output logic [5:0]  if_mode,
   output logic        an_enable,
   output logic        an_restart,
   output logic        sw_reset
);

   localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

   logic [15:0] control;
   logic [15:0] scratch;
   logic [15:1] lt_lo;
   logic [4:0]  lt_hi;
   logic [5:0]  ifm;
   logic [7:0]  rst_cnt;
   logic [15:0] rd_mux;

   // Read view of the map; unused bits and unmapped addresses read zero.
   always_comb begin
      rd_mux = '0;
      unique case (addr)
         ADDR_CTRL:    rd_mux = control;
         ADDR_STAT:    rd_mux = status_word(link_up, an_done);
         ADDR_SCRATCH: rd_mux = scratch;
         ADDR_LT_LO:   rd_mux = {lt_lo, 1'b0};
         ADDR_LT_HI:   rd_mux = {11'b0, lt_hi};
         ADDR_IF_MODE: rd_mux = {10'b0, ifm};
         default:      rd_mux = '0;
      endcase
   end

   // Register updates; a control write overrides the soft-reset expiry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         control    <= CTRL_RST;
         scratch    <= '0;
         lt_lo      <= '0;
         lt_hi      <= '0;
         ifm        <= '0;
         rst_cnt    <= '0;
         rdata      <= '0;
         an_restart <= 1'b0;
      end else begin
         an_restart <= 1'b0;
         if (control[CTRL_SW_RESET]) begin
            if (rst_cnt == RST_LAST) begin
               control[CTRL_SW_RESET] <= 1'b0;
            end else begin
               rst_cnt <= rst_cnt + 8'd1;
            end
         end
         if (commit && op_wr) begin
            unique case (addr)
               ADDR_CTRL: begin
                  control    <= {wdata[15:10], 1'b0, wdata[8:0]};
                  rst_cnt    <= '0;
                  an_restart <= wdata[CTRL_AN_RESTART];
               end
               ADDR_SCRATCH: scratch <= wdata;
               ADDR_LT_LO:   lt_lo   <= wdata[15:1];
               ADDR_LT_HI:   lt_hi   <= wdata[4:0];
               ADDR_IF_MODE: ifm     <= wdata[5:0];
               default: ;
            endcase
         end else if (commit) begin
            rdata <= rd_mux;
         end
      end
   end

   assign link_timer = {lt_hi, lt_lo, 1'b0};
   assign if_mode    = ifm;
   assign an_enable  = control[CTRL_AN_EN];
   assign sw_reset   = control[CTRL_SW_RESET];

endmodule

// File: rtl/sgmii_reg_responder.sv
// Responder end of the SGMII PCS management bus: handshake FSM.
// Busy high means ready/processing, busy low for one cycle means done.
module sgmii_reg_responder
   import sgmii_reg_responder_pkg::*;
#(
   parameter int INIT_CYCLES  = 16,
   parameter int ACCESS_LAT   = 2,
   parameter int RESET_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   sgmii_reg_if.slave  bus,
   input  logic        link_up,
   input  logic        an_done,
   output logic [20:0] link_timer,
   output logic [5:0]  if_mode,
   output logic        an_enable,
   output logic        an_restart,
   output logic        sw_reset
);

   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [7:0] ACC_LAST  = 8'(ACCESS_LAT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic        busy;
   logic [4:0]  op_addr;
   logic [15:0] op_data;
   logic        op_wr;
   logic        commit;
   logic [15:0] rdata;

   // Handshake FSM; requests are sampled only in IDLE, write wins over read.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_INIT;
         cnt     <= '0;
         busy    <= 1'b0;
         op_addr <= '0;
         op_data <= '0;
         op_wr   <= 1'b0;
      end else begin
         unique case (state)
            ST_INIT: begin
               if (cnt == INIT_LAST) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_IDLE: begin
               if (bus.reg_wr || bus.reg_rd) begin
                  op_addr <= bus.reg_addr;
                  op_data <= bus.reg_data_in;
                  op_wr   <= bus.reg_wr;
                  cnt     <= '0;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt == ACC_LAST) begin
                  state <= ST_DONE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b1;
            end
            default: begin
               state <= ST_INIT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign commit = (state == ST_ACCESS) && (cnt == ACC_LAST);

   sgmii_reg_file #(
      .RESET_CYCLES(RESET_CYCLES)
   ) u_reg_file (
      .clk        (clk),
      .reset      (reset),
      .commit     (commit),
      .op_wr      (op_wr),
      .addr       (op_addr),
      .wdata      (op_data),
      .link_up    (link_up),
      .an_done    (an_done),
      .rdata      (rdata),
      .link_timer (link_timer),
      .if_mode    (if_mode),
      .an_enable  (an_enable),
      .an_restart (an_restart),
      .sw_reset   (sw_reset)
   );

   assign bus.reg_busy     = busy;
   assign bus.reg_data_out = rdata;

endmodule

// File: tb/tb_sgmii_reg_responder.sv
// Scoreboard bench for sgmii_reg_responder.
// Master tasks push expected read data; a monitor checks each DONE cycle.
module tb_sgmii_reg_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        link_up = 1'b0;
   logic        an_done = 1'b0;
   logic [20:0] link_timer;
   logic [5:0]  if_mode;
   logic        an_enable;
   logic        an_restart;
   logic        sw_reset;

   sgmii_reg_if bus();

   sgmii_reg_responder dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .link_up    (link_up),
      .an_done    (an_done),
      .link_timer (link_timer),
      .if_mode    (if_mode),
      .an_enable  (an_enable),
      .an_restart (an_restart),
      .sw_reset   (sw_reset)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] sb_q[$];
   logic [15:0] m_regs[32];
   logic [15:0] last_rd;
   logic        prev_busy = 1'b0;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 16'h0;
      m_regs[0] = 16'h1140;
      last_rd = 16'h0;
   endfunction

   function automatic logic [15:0] model_read(logic [4:0] a);
      int s;
      case (a)
         5'h00: return m_regs[0];
         5'h01: begin
            s = 8 + (an_done ? 32 : 0) + (link_up ? 4 : 0);
            return 16'(s);
         end
         5'h10: return m_regs[16];
         5'h12: return m_regs[18] & 16'hFFFE;
         5'h13: return m_regs[19] & 16'h001F;
         5'h14: return m_regs[20] & 16'h003F;
         default: return 16'h0;
      endcase
   endfunction

   // Soft reset and AN restart are transient; the model keeps the stable part.
   function automatic void model_write(logic [4:0] a, logic [15:0] d);
      case (a)
         5'h00: m_regs[0] = d & 16'h7DFF;
         5'h10, 5'h12, 5'h13, 5'h14: m_regs[a] = d;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] model_lt();
      int v;
      v = (int'(m_regs[19] & 16'h1F) * 65536) + int'(m_regs[18] & 16'hFFFE);
      return 32'(v);
   endfunction

   always @(negedge clk) begin : monitor
      logic [15:0] e;
      if (reset && prev_busy && !bus.reg_busy) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("rdata", bus.reg_data_out, e);
         end
      end
      prev_busy = bus.reg_busy;
   end

   task automatic wait_init(string nm);
      int n;
      n = 0;
      while (!bus.reg_busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk(nm, n, 16);
   endtask

   task automatic access(input logic wr, input logic rd,
                         input logic [4:0] a, input logic [15:0] d,
                         input logic hold, output logic rs,
                         output logic sw);
      int n;
      n = 0;
      while (!bus.reg_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("idle_timeout", 1, 0);
      bus.reg_wr = wr;
      bus.reg_rd = rd;
      bus.reg_addr = a;
      bus.reg_data_in = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.reg_busy && n < 50);
      chk("latency", n, 3);
      rs = an_restart;
      sw = sw_reset;
      if (!hold) begin
         bus.reg_wr = 1'b0;
         bus.reg_rd = 1'b0;
      end
      @(negedge clk);
      chk("done_one_cycle", bus.reg_busy, 1);
      bus.reg_wr = 1'b0;
      bus.reg_rd = 1'b0;
   endtask

   task automatic xact(input logic wr, input logic rd,
                       input logic [4:0] a, input logic [15:0] d,
                       input logic hold, output logic rs,
                       output logic sw);
      if (wr) begin
         model_write(a, d);
         sb_q.push_back(last_rd);
      end else begin
         last_rd = model_read(a);
         sb_q.push_back(last_rd);
      end
      access(wr, rd, a, d, hold, rs, sw);
   endtask

   logic        rs;
   logic        sw;
   logic [4:0]  ra;
   logic [15:0] rd_val;
   logic [4:0]  addr_tab[6];
   int          n;

   initial begin
      addr_tab[0] = 5'h01;
      addr_tab[1] = 5'h10;
      addr_tab[2] = 5'h12;
      addr_tab[3] = 5'h13;
      addr_tab[4] = 5'h14;
      addr_tab[5] = 5'h1F;
      bus.reg_wr = 1'b0;
      bus.reg_rd = 1'b0;
      bus.reg_addr = '0;
      bus.reg_data_in = '0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.reg_busy, 0);
      chk("rst_data_out", bus.reg_data_out, 0);
      chk("rst_link_timer", link_timer, 0);
      chk("rst_if_mode", if_mode, 0);
      chk("rst_an_enable", an_enable, 1);
      chk("rst_an_restart", an_restart, 0);
      chk("rst_sw_reset", sw_reset, 0);
      reset = 1'b1;
      wait_init("init_busy_low");

      xact(1, 0, 5'h12, 16'h0d40, 0, rs, sw);
      xact(1, 0, 5'h13, 16'h0003, 0, rs, sw);
      chk("link_timer", link_timer, 32'h030d40);

      xact(1, 0, 5'h00, 16'h1340, 0, rs, sw);
      chk("an_restart_pulse", rs, 1);
      chk("an_restart_clear", an_restart, 0);
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);
      xact(1, 0, 5'h00, 16'h0140, 0, rs, sw);
      chk("an_enable_off", an_enable, 0);
      chk("an_restart_none", rs, 0);
      xact(1, 0, 5'h00, 16'h1140, 0, rs, sw);
      chk("an_enable_on", an_enable, 1);

      xact(1, 0, 5'h00, 16'h9140, 0, rs, sw);
      n = sw ? 1 : 0;
      while (sw_reset && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("sw_reset_len", n, 8);
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);
      xact(1, 0, 5'h00, 16'h9140, 0, rs, sw);
      m_regs[0] = 16'h9140;
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);
      m_regs[0] = 16'h1140;
      repeat (12) @(negedge clk);
      chk("sw_reset_done", sw_reset, 0);
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);

      link_up = 1'b1;
      an_done = 1'b1;
      xact(0, 1, 5'h01, 16'h0, 0, rs, sw);
      chk("status_value", last_rd, 16'h002C);
      xact(0, 1, 5'h1F, 16'h0, 0, rs, sw);
      xact(1, 0, 5'h1F, 16'hFFFF, 0, rs, sw);
      chk("unmapped_lt", link_timer, 32'h030d40);
      chk("unmapped_ifm", if_mode, 0);
      xact(0, 1, 5'h10, 16'h0, 0, rs, sw);
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);

      xact(1, 1, 5'h10, 16'hA5A5, 0, rs, sw);
      xact(0, 1, 5'h10, 16'h0, 0, rs, sw);
      chk("wr_rd_scratch", last_rd, 16'hA5A5);
      xact(1, 0, 5'h10, 16'h5A5A, 1, rs, sw);
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (!bus.reg_busy) n++;
      end
      chk("no_extra_access", n, 0);
      xact(0, 1, 5'h10, 16'h0, 0, rs, sw);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 5'($urandom_range(2, 31));
         else ra = addr_tab[$urandom_range(0, 5)];
         link_up = 1'($urandom_range(0, 1));
         an_done = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1)
            xact(1, 1'($urandom_range(0, 1)), ra, 16'($urandom), 0, rs, sw);
         else
            xact(0, 1, ra, 16'h0, 0, rs, sw);
      end
      chk("rand_link_timer", link_timer, model_lt());
      chk("rand_if_mode", if_mode, 32'(m_regs[20] & 16'h3F));

      bus.reg_wr = 1'b1;
      bus.reg_addr = 5'h14;
      bus.reg_data_in = 16'h0003;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.reg_wr = 1'b0;
      sb_q.delete();
      model_reset();
      @(negedge clk);
      chk("mid_rst_busy", bus.reg_busy, 0);
      chk("mid_rst_ifm", if_mode, 0);
      chk("mid_rst_data_out", bus.reg_data_out, 0);
      chk("mid_rst_lt", link_timer, 0);
      @(negedge clk);
      reset = 1'b1;
      wait_init("reinit_busy_low");
      chk("post_rst_ifm", if_mode, 0);
      xact(0, 1, 5'h14, 16'h0, 0, rs, sw);
      xact(0, 1, 5'h00, 16'h0, 0, rs, sw);

      repeat (5) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
